// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS32 memory stage: ALU opcodes, write/reset constants,
// FSM state encoding and opcode classification helpers.
package mem_stage_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: bad = a[0];
            EXE_LW_OP, EXE_SW_OP:             bad = (a != 2'b00);
            default:                          bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// Big-endian byte-lane steering: store byte enables and lane replication, plus
// selection and sign/zero extension of load data from the captured bus word.
module mem_lane
    import mem_stage_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (a_i)
            2'd0: byte_sel = rdata_i[31:24];
            2'd1: byte_sel = rdata_i[23:16];
            2'd2: byte_sel = rdata_i[15:8];
            2'd3: byte_sel = rdata_i[7:0];
        endcase
    end

    assign half_sel = a_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        sel_o       = 4'b1111;
        wdata_o     = rt_i;
        load_data_o = rdata_i;
        case (aluop_i)
            EXE_LB_OP: begin
                sel_o       = 4'b1000 >> a_i;
                load_data_o = {{24{byte_sel[7]}}, byte_sel};
            end
            EXE_LBU_OP: begin
                sel_o       = 4'b1000 >> a_i;
                load_data_o = {24'h0, byte_sel};
            end
            EXE_LH_OP: begin
                sel_o       = a_i[1] ? 4'b0011 : 4'b1100;
                load_data_o = {{16{half_sel[15]}}, half_sel};
            end
            EXE_LHU_OP: begin
                sel_o       = a_i[1] ? 4'b0011 : 4'b1100;
                load_data_o = {16'h0, half_sel};
            end
            EXE_SB_OP: begin
                sel_o   = 4'b1000 >> a_i;
                wdata_o = {4{rt_i[7:0]}};
            end
            EXE_SH_OP: begin
                sel_o   = a_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{rt_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: runs loads/stores over a req/ack data bus and stalls until ack.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses on excp_misalign.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_hi,
    input  logic [DATA_W-1:0] ex_lo,
    input  logic              ex_whilo,
    input  logic [7:0]        ex_aluop,
    input  logic [31:0]       ex_mem_addr,
    input  logic [DATA_W-1:0] ex_reg2,
    input  logic [DATA_W-1:0] dbus_rdata,
    input  logic              dbus_ack,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_hi,
    output logic [DATA_W-1:0] mem_lo,
    output logic              mem_whilo,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_wdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              excp_misalign,
`endif
    output logic              stall_req
);

    mem_state_e  state_q;
    logic [31:0] rdata_q;
    logic        load_op;
    logic        store_op;
    logic        misalign;
    logic        issue;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign load_op  = is_load(ex_aluop);
    assign store_op = is_store(ex_aluop);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (load_op | store_op) & is_misaligned(ex_aluop, ex_mem_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign issue = (load_op | store_op) & ~misalign;

    mem_lane u_lane (
        .aluop_i     (ex_aluop),
        .a_i         (ex_mem_addr[1:0]),
        .rt_i        (ex_reg2),
        .rdata_i     (rdata_q),
        .sel_o       (lane_sel),
        .wdata_o     (lane_wdata),
        .load_data_o (load_data)
    );

    // An ack is only meaningful while a request is outstanding; reset drops any in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst == RstEnable) begin
            state_q <= MEM_IDLE;
            rdata_q <= ZeroWord;
        end else begin
            unique case (state_q)
                MEM_IDLE: begin
                    if (issue) begin
                        if (dbus_ack) begin
                            state_q <= MEM_DONE;
                            rdata_q <= dbus_rdata;
                        end else begin
                            state_q <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (dbus_ack) begin
                        state_q <= MEM_DONE;
                        rdata_q <= dbus_rdata;
                    end
                end
                MEM_DONE: state_q <= MEM_IDLE;
                default:  state_q <= MEM_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        mem_whilo = ex_whilo;
        dbus_req  = 1'b0;
        stall_req = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        excp_misalign = 1'b0;
`endif
        unique case (state_q)
            MEM_IDLE: begin
                dbus_req  = issue;
                stall_req = issue;
`ifdef MEM_ALIGN_CHECK_EN
                excp_misalign = misalign;
`endif
                if (issue | misalign) begin
                    mem_wreg  = WriteDisable;
                    mem_whilo = WriteDisable;
                end
            end
            MEM_WAIT: begin
                dbus_req  = 1'b1;
                stall_req = 1'b1;
                mem_wreg  = WriteDisable;
                mem_whilo = WriteDisable;
            end
            MEM_DONE: begin
                if (store_op) begin
                    mem_wreg = WriteDisable;
                end else if (load_op) begin
                    mem_wdata = load_data;
                end
            end
            default: ;
        endcase
        if (rst == RstEnable) begin
            mem_wd    = NOPRegAddr;
            mem_wreg  = WriteDisable;
            mem_wdata = ZeroWord;
            mem_hi    = ZeroWord;
            mem_lo    = ZeroWord;
            mem_whilo = WriteDisable;
            dbus_req  = 1'b0;
            stall_req = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            excp_misalign = 1'b0;
`endif
        end
    end

    assign dbus_addr  = (rst == RstEnable) ? '0 : {ex_mem_addr[ADDR_W-1:2], 2'b00};
    assign dbus_we    = dbus_req & store_op;
    assign dbus_sel   = dbus_req ? lane_sel : 4'b0000;
    assign dbus_wdata = (rst == RstEnable) ? ZeroWord : lane_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected mem_wb results are queued at issue and
// compared when the stage releases its stall.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2, dbus_rdata;
    logic        dbus_ack;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        dbus_req, dbus_we, stall_req;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_sel;
`ifdef MEM_ALIGN_CHECK_EN
    logic        excp_misalign;
`endif

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_hi       (ex_hi),
        .ex_lo       (ex_lo),
        .ex_whilo    (ex_whilo),
        .ex_aluop    (ex_aluop),
        .ex_mem_addr (ex_mem_addr),
        .ex_reg2     (ex_reg2),
        .dbus_rdata  (dbus_rdata),
        .dbus_ack    (dbus_ack),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_hi      (mem_hi),
        .mem_lo      (mem_lo),
        .mem_whilo   (mem_whilo),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_sel    (dbus_sel),
        .dbus_wdata  (dbus_wdata),
`ifdef MEM_ALIGN_CHECK_EN
        .excp_misalign (excp_misalign),
`endif
        .stall_req   (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model, written from the big-endian lane rules.
    function automatic logic m_is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [1:0] a);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP)
            return 4'(1 << (3 - int'(a)));
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP)
            return a[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_bus_wdata(input logic [7:0] op, input logic [31:0] rt);
        if (op == EXE_SB_OP) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
        if (op == EXE_SH_OP) return {rt[15:0], rt[15:0]};
        return rt;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = w >> ((3 - int'(a)) * 8);
        h = a[1] ? w : (w >> 16);
        case (op)
            EXE_LB_OP:  return {{24{b[7]}}, b[7:0]};
            EXE_LBU_OP: return {24'h0, b[7:0]};
            EXE_LH_OP:  return {{16{h[15]}}, h[15:0]};
            EXE_LHU_OP: return {16'h0, h[15:0]};
            default:    return w;
        endcase
    endfunction

    task automatic commit(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_wd"}, {27'h0, mem_wd}, {27'h0, e.wd});
        check({tag, "_wreg"}, {31'h0, mem_wreg}, {31'h0, e.wreg});
        check({tag, "_wdata"}, mem_wdata, e.wdata);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wd"}, {27'h0, mem_wd}, 32'h0);
        check({tag, "_wreg"}, {31'h0, mem_wreg}, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_hi"}, mem_hi, 32'h0);
        check({tag, "_lo"}, mem_lo, 32'h0);
        check({tag, "_whilo"}, {31'h0, mem_whilo}, 32'h0);
        check({tag, "_req"}, {31'h0, dbus_req}, 32'h0);
        check({tag, "_stall"}, {31'h0, stall_req}, 32'h0);
        check({tag, "_sel"}, {28'h0, dbus_sel}, 32'h0);
        check({tag, "_addr"}, dbus_addr, 32'h0);
    endtask

    task automatic alu_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo);
        exp_t e;
        @(negedge clk);
        ex_aluop = EXE_ADD_OP; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_hi = $urandom; ex_lo = $urandom; ex_whilo = whilo;
        ex_mem_addr = $urandom; ex_reg2 = $urandom; dbus_ack = 1'b0;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata;
        sb.push_back(e);
        #1;
        check("alu_stall", {31'h0, stall_req}, 32'h0);
        check("alu_req", {31'h0, dbus_req}, 32'h0);
        check("alu_hi", mem_hi, ex_hi);
        check("alu_lo", mem_lo, ex_lo);
        check("alu_whilo", {31'h0, mem_whilo}, {31'h0, whilo});
        commit("alu");
    endtask

    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rdata, input int delay);
        exp_t e;
        int   stalls;
        bit   done;
        logic st;
        st = m_is_store(op);
        stalls = 0;
        done = 1'b0;
        @(negedge clk);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = rt;
        ex_wd = 5'($urandom_range(1, 31)); ex_wreg = 1'b1; ex_wdata = $urandom;
        ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'b0;
        e.wd = ex_wd;
        e.wreg = !st;
        e.wdata = st ? ex_wdata : m_load(op, addr[1:0], rdata);
        sb.push_back(e);
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk);
            dbus_ack = (k == delay);
            dbus_rdata = (k == delay) ? rdata : $urandom;
            #1;
            if (stall_req) begin
                stalls++;
                check("mem_req", {31'h0, dbus_req}, 32'h1);
                check("mem_bubble_wreg", {31'h0, mem_wreg}, 32'h0);
                check("mem_addr", dbus_addr, {addr[31:2], 2'b00});
                check("mem_sel", {28'h0, dbus_sel}, {28'h0, m_sel(op, addr[1:0])});
                check("mem_we", {31'h0, dbus_we}, {31'h0, st});
                if (st) check("mem_bus_wdata", dbus_wdata, m_bus_wdata(op, rt));
            end else begin
                check("done_req", {31'h0, dbus_req}, 32'h0);
                commit("mem");
                done = 1'b1;
            end
        end
        if (!done) check("mem_timeout", 32'd0, 32'd1);
        check("mem_stall_cycles", 32'(stalls), 32'(delay + 1));
    endtask

    initial begin
        logic [7:0] ops [8];
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

        rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        ex_aluop = EXE_LW_OP; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_0001;
        ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; ex_whilo = 1'b1;
        ex_mem_addr = 32'h0000_0104; ex_reg2 = 32'h3333_3333;
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        ex_aluop = EXE_NOP_OP; ex_wreg = 1'b0;

        alu_op(5'd3, 1'b1, 32'h1234_5678, 1'b1);
        do_op(EXE_LW_OP, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
        do_op(EXE_LB_OP, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1);
        do_op(EXE_LBU_OP, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);
        do_op(EXE_LH_OP, 32'h0000_0102, 32'h0, 32'h1234_8001, 2);
        do_op(EXE_LHU_OP, 32'h0000_0100, 32'h0, 32'h9ABC_0000, 0);
        do_op(EXE_SH_OP, 32'h0000_0202, 32'hAAAA_5555, 32'h0, 0);
        do_op(EXE_SB_OP, 32'h0000_0201, 32'h0000_0077, 32'h0, 2);
        do_op(EXE_SW_OP, 32'h0000_0300, 32'h0123_4567, 32'h0, 1);
        alu_op(5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h0000_0101; ex_wreg = 1'b1; dbus_ack = 1'b0;
        #1;
        check("mis_excp", {31'h0, excp_misalign}, 32'h1);
        check("mis_req", {31'h0, dbus_req}, 32'h0);
        check("mis_stall", {31'h0, stall_req}, 32'h0);
        check("mis_wreg", {31'h0, mem_wreg}, 32'h0);
        @(negedge clk);
        ex_aluop = EXE_NOP_OP; ex_wreg = 1'b0;
        #1 check("mis_excp_clear", {31'h0, excp_misalign}, 32'h0);
`else
        do_op(EXE_LW_OP, 32'h0000_0101, 32'h0, 32'h0BAD_CAFE, 0);
        do_op(EXE_LH_OP, 32'h0000_0103, 32'h0, 32'h0000_7FFE, 1);
`endif

        // Reset while waiting for ack; the late ack must be dropped.
        @(negedge clk);
        ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h0000_0400; ex_wd = 5'd9; ex_wreg = 1'b1;
        dbus_ack = 1'b0;
        #1 check("rst_issue_stall", {31'h0, stall_req}, 32'h1);
        @(negedge clk);
        #1 check("rst_wait_stall", {31'h0, stall_req}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        dbus_ack = 1'b1; dbus_rdata = 32'h5A5A_5A5A;
        #1 check_zero("rst_ack");
        @(negedge clk);
        dbus_ack = 1'b0; rst = 1'b1;
        ex_aluop = EXE_NOP_OP; ex_wreg = 1'b0; ex_wd = 5'd0;
        #1;
        check("rst_after_stall", {31'h0, stall_req}, 32'h0);
        check("rst_after_req", {31'h0, dbus_req}, 32'h0);
        check("rst_after_wreg", {31'h0, mem_wreg}, 32'h0);
        do_op(EXE_LW_OP, 32'h0000_0404, 32'h0, 32'h600D_F00D, 1);

        for (int i = 0; i < 16; i++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            op = ops[$urandom_range(0, 7)];
            addr = {16'h0, 14'($urandom), 2'b00};
            if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP)
                addr[1:0] = 2'($urandom);
            else if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP)
                addr[1] = 1'($urandom);
            do_op(op, addr, $urandom, $urandom, $urandom_range(0, 3));
            if (i % 4 == 3) alu_op(5'($urandom), 1'b1, $urandom, 1'($urandom));
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS32 pipeline. Sits between the ex_mem pipeline register and the mem_wb pipeline register.
- Executes loads and stores over a request/acknowledge data bus, and stalls the pipeline until the bus acknowledges.
- For non-memory instructions it passes the EX results (register write, HI/LO write) straight through to mem_wb.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, data width; fixed at 32, used for documentation and checks only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (RstEnable = 1'b0).
- ex_wd  in  5  destination register address.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  32  ALU result for non-load instructions.
- ex_hi  in  32  HI value.
- ex_lo  in  32  LO value.
- ex_whilo  in  1  HI/LO write enable.
- ex_aluop  in  8  operation code; memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW.
- ex_mem_addr  in  32  effective address.
- ex_reg2  in  32  store data (rt).
- dbus_rdata  in  32  bus read data.
- dbus_ack  in  1  bus acknowledge; one-cycle pulse.
- mem_wd  out  5  to mem_wb.
- mem_wreg  out  1  to mem_wb.
- mem_wdata  out  32  to mem_wb.
- mem_hi  out  32  to mem_wb.
- mem_lo  out  32  to mem_wb.
- mem_whilo  out  1  to mem_wb.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  ADDR_W  word-aligned address, {ex_mem_addr[31:2],2'b00}.
- dbus_sel  out  4  byte enables.
- dbus_wdata  out  32  lane-replicated store data.
- stall_req  out  1  to ctrl; freezes PC, if_id, id_ex and ex_mem.

Behaviour:
- Reset:
  - While rst==0 all outputs are forced to zero: wd = NOPRegAddr, wreg/whilo = WriteDisable, data = ZeroWord.
  - dbus_req=0 and stall_req=0 during reset.
  - At the clock edge with rst==0, the FSM goes to IDLE and the load-data register clears to 0.
  - Reset mid-transaction abandons the bus cycle; any later ack is ignored.
- FSM states:
  - IDLE: a memory op on the inputs asserts dbus_req=1 and stall_req=1 combinationally. dbus_ack=1 in the same cycle → DONE, else → WAIT. A non-memory op stays in IDLE.
  - WAIT: dbus_req=1, stall_req=1. dbus_ack=1 → DONE and capture dbus_rdata. Otherwise stay.
  - DONE: dbus_req=0, stall_req=0 and load result valid for exactly one cycle; then → IDLE unconditionally.
- Latency: a memory op occupies the stage for 2 cycles minimum (ack in the first cycle); each ack wait cycle adds one.
- ex_* inputs are held stable by ctrl while stall_req=1.
- While stall_req=1, mem_wreg=0 and mem_whilo=0 (bubble into mem_wb); other outputs pass through.
- Non-memory ops: all mem_* outputs equal the ex_* inputs combinationally.
- Stores: mem_wreg=0 in DONE.
- dbus_we=1 for SB/SH/SW; dbus_addr, dbus_we and dbus_sel are held constant for the whole request.
- Byte lanes (big-endian), with a = ex_mem_addr[1:0]:
  - Byte ops: sel = 1000 >> a; SB wdata = {4{rt[7:0]}}.
  - Half ops: a[1]=0 → 1100, a[1]=1 → 0011; SH wdata = {2{rt[15:0]}}.
  - Word ops: sel = 1111.
- Load extraction from the captured word:
  - LB sign-extends the selected byte; LBU zero-extends it.
  - LH/LHU do the same for the selected halfword.
  - LW passes the word.
  - mem_wdata presents the extended value in DONE.
- Misaligned half/word addresses ignore the low bits (word access) unless the optional feature is compiled in.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Adds output excp_misalign (1 bit).
  - For LH/LHU/SH with a[0]=1, or LW/SW with a≠0: no bus request, excp_misalign=1 for one cycle, mem_wreg=0, no stall.
  - The FSM stays in IDLE.
- Undefined: no port; misaligned accesses behave as described in Behaviour.

Decomposition:
- Shared package define.v holds:
  - The aluop encodings (EXE_LB_OP … EXE_SW_OP).
  - RstEnable, WriteDisable, ZeroWord, NOPRegAddr, RegBus, RegAddrBus.
  - State encodings MEM_IDLE=2'd0, MEM_WAIT=2'd1, MEM_DONE=2'd2.
- One natural sub-module, mem_lane, is purely combinational:
  - Inputs: aluop, a, rt, rdata.
  - Outputs: sel, wdata, load result.

Test Plan:
- ALU pass-through: ADD result ex_wdata=0x1234_5678, wd=5'd3, wreg=1 → mem_* mirror inputs the same cycle, stall_req=0, dbus_req=0.
- LW with 3-cycle ack delay: addr 0x100, rdata 0xDEADBEEF → stall_req high 4 cycles, then DONE with mem_wdata=0xDEADBEEF and wreg=1; mem_wreg=0 while stalled.
- LB sign extension: addr 0x103, rdata 0x000000F0 → sel=0001, mem_wdata=0xFFFFFFF0. LBU, same stimulus → 0x000000F0.
- SH: addr 0x202, rt=0xAAAA_5555, ack immediate → dbus_we=1, sel=0011, wdata=0x5555_5555, 2-cycle occupancy, mem_wreg=0.
- Reset pulled low in WAIT, ack arriving the cycle after → FSM in IDLE, all outputs zero, ack ignored, no register write.
- With MEM_ALIGN_CHECK_EN: LW at 0x101 → excp_misalign=1, dbus_req=0, stall_req=0, mem_wreg=0.
